// File: rtl/shift_amount_selector.sv
// Registered shifter-control decode for ARM data-processing operand 2.
// Produces the shift/rotate amount, the shift type and the RRX and shift-by-32 flags, one cycle after input.
module shift_amount_selector (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        S,
  input  logic [31:0] I0,
  output logic [4:0]  Y,
  output logic [1:0]  shift_type,
  output logic        amount_32,
  output logic        rrx,
  output logic        out_valid
);

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  logic [4:0] next_y;
  logic [1:0] next_type;
  logic       next_amount_32;
  logic       next_rrx;

  // Only the operand-2 shift fields matter; the rest of the word is deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{I0[31:12], I0[4:0]};

  always_comb begin
    next_y         = I0[11:7];
    next_type      = I0[6:5];
    next_amount_32 = 1'b0;
    next_rrx       = 1'b0;
    if (S) begin
      next_y    = {I0[11:8], 1'b0};
      next_type = SHIFT_ROR;
    end else if (I0[11:7] == 5'd0) begin
      // A zero immediate re-encodes LSR/ASR as shift-by-32 and ROR as RRX.
      unique case (I0[6:5])
        SHIFT_LSR, SHIFT_ASR: next_amount_32 = 1'b1;
        SHIFT_ROR:            next_rrx       = 1'b1;
        SHIFT_LSL:            next_amount_32 = 1'b0;
        default:              next_amount_32 = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y          <= 5'd0;
      shift_type <= SHIFT_LSL;
      amount_32  <= 1'b0;
      rrx        <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y          <= next_y;
        shift_type <= next_type;
        amount_32  <= next_amount_32;
        rrx        <= next_rrx;
      end
    end
  end

endmodule

// File: tb/tb_shift_amount_selector.sv
// Directed, table-driven bench for shift_amount_selector.
module tb_shift_amount_selector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        S;
  logic [31:0] I0;
  logic [4:0]  Y;
  logic [1:0]  shift_type;
  logic        amount_32;
  logic        rrx;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        s;
    logic [31:0] i0;
    logic [4:0]  y;
    logic [1:0]  t;
    logic        a32;
    logic        rx;
  } vec_t;

  vec_t vecs[11];

  shift_amount_selector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .S         (S),
    .I0        (I0),
    .Y         (Y),
    .shift_type(shift_type),
    .amount_32 (amount_32),
    .rrx       (rrx),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic [31:0] i0, input logic v);
    @(negedge clk);
    S        = s;
    I0       = i0;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] ey, input logic [1:0] et,
                             input logic ea, input logic er, input logic ev);
    logic [9:0] got;
    logic [9:0] exp;
    got = {Y, shift_type, amount_32, rrx, out_valid};
    exp = {ey, et, ea, er, ev};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got Y=%0d type=%b a32=%b rrx=%b ov=%b, expected Y=%0d type=%b a32=%b rrx=%b ov=%b",
               name, Y, shift_type, amount_32, rrx, out_valid, ey, et, ea, er, ev);
    end
  endtask

  initial begin
    vecs[0]  = '{"all_ones_s0",   1'b0, 32'hFFFF_FFFF, 5'd31, 2'b11, 1'b0, 1'b0};
    vecs[1]  = '{"all_ones_s1",   1'b1, 32'hFFFF_FFFF, 5'd30, 2'b11, 1'b0, 1'b0};
    vecs[2]  = '{"zero_lsr",      1'b0, 32'h0000_0020, 5'd0,  2'b01, 1'b1, 1'b0};
    vecs[3]  = '{"zero_asr",      1'b0, 32'h0000_0040, 5'd0,  2'b10, 1'b1, 1'b0};
    vecs[4]  = '{"zero_ror_rrx",  1'b0, 32'h0000_0060, 5'd0,  2'b11, 1'b0, 1'b1};
    vecs[5]  = '{"zero_lsl",      1'b0, 32'hFFFF_F01F, 5'd0,  2'b00, 1'b0, 1'b0};
    vecs[6]  = '{"rot_7",         1'b1, 32'h0000_0700, 5'd14, 2'b11, 1'b0, 1'b0};
    vecs[7]  = '{"lsr_21",        1'b0, 32'h0000_0AA0, 5'd21, 2'b01, 1'b0, 1'b0};
    vecs[8]  = '{"rot_0",         1'b1, 32'hFFFF_F0FF, 5'd0,  2'b11, 1'b0, 1'b0};
    vecs[9]  = '{"s1_no_rrx",     1'b1, 32'h0000_0060, 5'd0,  2'b11, 1'b0, 1'b0};
    vecs[10] = '{"ror_1",         1'b0, 32'h0000_00E0, 5'd1,  2'b11, 1'b0, 1'b0};

    rst_n    = 1'b1;
    in_valid = 1'b0;
    S        = 1'b0;
    I0       = 32'd0;

    #3 rst_n = 1'b0;
    #1 checkOutput("reset_async", 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0);
    checkOutput("idle_after_release", 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].s, vecs[i].i0, 1'b1);
      checkOutput(vecs[i].name, vecs[i].y, vecs[i].t, vecs[i].a32, vecs[i].rx, 1'b1);
    end

    // Rotate field 0111 with every ignored bit randomised
    for (int i = 0; i < 4; i++) begin
      logic [31:0] r;
      r = $urandom;
      applyStimulus(1'b1, {r[31:12], 4'b0111, r[7:0]}, 1'b1);
      checkOutput("rot_7_random", 5'd14, 2'b11, 1'b0, 1'b0, 1'b1);
    end

    applyStimulus(1'b0, 32'h0000_0AA0, 1'b1);
    checkOutput("hold_setup", 5'd21, 2'b01, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0);
      checkOutput("hold_idle", 5'd21, 2'b01, 1'b0, 1'b0, 1'b0);
    end

    #2 rst_n = 1'b0;
    #1 checkOutput("reset_mid_cycle", 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0000_0040, 1'b1);
    checkOutput("first_after_reset", 5'd0, 2'b10, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
